// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared memory-visit codes, sizing and arbiter state encoding
package mem_port_arbiter_pkg;
  localparam int ADDR_WIDTH = 17;
  localparam int LEN = 32;
  localparam int ENTRY_INDEX_SIZE = 3;
  localparam int BURST_BEATS = 8;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W = ENTRY_INDEX_SIZE + 1;
  localparam logic [1:0] MEM_NOP = 2'b00;
  localparam logic [1:0] MEM_READ = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [1:0] MEM_READ_BURST = 2'b11;
  localparam logic [1:0] MEM_FINISHED = 2'b00;
  localparam logic [1:0] MEM_DATA_WORKING = 2'b01;
  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_BURST, D_WR, COOL} arb_state_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: cache request/response and main-memory visit signals
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;
  logic i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [LEN-1:0] i_rdata;
  logic i_done;
  logic d_req;
  logic [1:0] d_op;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [CNT_W-1:0] d_len;
  logic [LEN-1:0] d_wdata;
  logic [LEN-1:0] d_rdata;
  logic d_beat;
  logic d_done;
  logic [1:0] mem_i_signal;
  logic [1:0] mem_d_signal;
  logic [ADDR_WIDTH-1:0] mem_i_addr;
  logic [ADDR_WIDTH-1:0] mem_d_addr;
  logic [CNT_W-1:0] mem_length;
  logic [LEN-1:0] mem_wdata;
  logic [LEN-1:0] mem_rdata;
  logic [1:0] mem_status;
  modport slave (
    input i_req, i_addr, d_req, d_op, d_addr, d_len, d_wdata, mem_rdata, mem_status,
    output i_rdata, i_done, d_rdata, d_beat, d_done, mem_i_signal, mem_d_signal,
    mem_i_addr, mem_d_addr, mem_length, mem_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_op, d_addr, d_len, d_wdata, mem_rdata, mem_status,
    input i_rdata, i_done, d_rdata, d_beat, d_done, mem_i_signal, mem_d_signal,
    mem_i_addr, mem_d_addr, mem_length, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_beat_counter.sv
// mem_beat_counter: per-transaction beat count, word address offset and last-beat flag
module mem_beat_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic [CNT_W-1:0] last_idx,
  output logic [CNT_W-1:0] cnt,
  output logic [ADDR_WIDTH-1:0] offset,
  output logic last
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    last = cnt_q == last_idx;
    cnt_d = (run && !last) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
  assign cnt = cnt_q;
  assign offset = ADDR_WIDTH'({cnt_q, 2'b00});
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants the single main-memory port to the I- or D-cache, D first with a starvation guard
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  arb_state_e state_q, state_d;
  logic [2:0] starve_q, starve_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, offset;
  logic [CNT_W-1:0] len_q, len_d, last_idx, cnt;
  logic busy, last, grant_d, grant_i, rd0, i_done, d_beat;
  mem_beat_counter u_cnt (.clk, .rst_n, .run(busy), .last_idx, .cnt, .offset, .last);
  always_comb begin
    busy = state_q inside {I_RD, D_RD, D_BURST, D_WR};
    grant_d = state_q == IDLE && bus.d_req && !(bus.i_req && starve_q == 3'(STARVE_LIMIT));
    grant_i = state_q == IDLE && !grant_d && bus.i_req;
    last_idx = state_q == D_BURST ? CNT_W'(BURST_BEATS) : state_q == D_WR ? len_q - 1'b1 : CNT_W'(1);
    state_d = busy && last ? COOL : state_q == COOL ? IDLE : state_q;
    if (grant_i) state_d = I_RD;
    if (grant_d) state_d = bus.d_op == MEM_WRITE ? D_WR : bus.d_op == MEM_READ_BURST ? D_BURST : D_RD;
    starve_d = grant_i ? '0 : (grant_d && bus.i_req && starve_q != 3'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
    addr_d = grant_d ? bus.d_addr : grant_i ? bus.i_addr : addr_q;
    len_d = grant_d ? bus.d_len : len_q;
  end
  // memory reads the i-address for any single read, so a D read is steered onto mem_i_addr
  always_comb begin
    rd0 = cnt == '0;
    i_done = state_q == I_RD && last;
    d_beat = (state_q == D_RD && last) || (state_q == D_BURST && !rd0) || state_q == D_WR;
    bus.i_done = i_done;
    bus.d_beat = d_beat;
    bus.d_done = state_q inside {D_RD, D_BURST, D_WR} && last;
    bus.i_rdata = i_done ? bus.mem_rdata : '0;
    bus.d_rdata = d_beat && state_q != D_WR ? bus.mem_rdata : '0;
    bus.mem_i_signal = state_q == I_RD && rd0 ? MEM_READ : MEM_NOP;
    bus.mem_d_signal = state_q == D_RD && rd0 ? MEM_READ : state_q == D_BURST ? MEM_READ_BURST :
                       state_q == D_WR ? MEM_WRITE : MEM_NOP;
    bus.mem_i_addr = state_q inside {I_RD, D_RD} && rd0 ? addr_q : '0;
    bus.mem_d_addr = state_q inside {D_BURST, D_WR} ? addr_q + offset : '0;
    bus.mem_length = state_q == D_WR ? len_q : '0;
    bus.mem_wdata = state_q == D_WR ? bus.d_wdata : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      starve_q <= '0;
      addr_q <= '0;
      len_q <= '0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      addr_q <= addr_d;
      len_q <= len_d;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == D_BURST && !rd0) |-> bus.mem_status == MEM_DATA_WORKING);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks against a word-level memory reference model
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  logic clk = 0;
  logic rst_n;
  int ncmp = 0, nerr = 0;
  int cyc, dcyc, icyc, who, c, exp_who;
  logic [16:0] ia, da, a;
  logic [31:0] dq [$];
  logic [31:0] store [0:32767];
  bit written [0:32767];
  logic [31:0] ref_mem [int];
  mem_port_arbiter_if bus ();
  mem_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] init_word(input logic [14:0] w);
    return {w, 17'h0} ^ (32'h9E3779B9 * {17'h0, w});
  endfunction
  function automatic logic [31:0] mem_word(input logic [14:0] w);
    return written[w] ? store[w] : init_word(w);
  endfunction
  function automatic logic [31:0] ref_word(input logic [14:0] w);
    return ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : init_word(w);
  endfunction
  always @(posedge clk) begin
    if (bus.mem_d_signal == MEM_WRITE) begin
      store[bus.mem_d_addr[16:2]] <= bus.mem_wdata;
      written[bus.mem_d_addr[16:2]] <= 1'b1;
    end
    if (bus.mem_i_signal == MEM_READ || bus.mem_d_signal == MEM_READ) bus.mem_rdata <= mem_word(bus.mem_i_addr[16:2]);
    else if (bus.mem_d_signal == MEM_READ_BURST) bus.mem_rdata <= mem_word(bus.mem_d_addr[16:2]);
    bus.mem_status <= bus.mem_d_signal == MEM_READ_BURST ? MEM_DATA_WORKING : MEM_FINISHED;
  end
  function automatic logic [255:0] all_out();
    return 256'({bus.i_rdata, bus.i_done, bus.d_rdata, bus.d_beat, bus.d_done, bus.mem_i_signal,
                 bus.mem_d_signal, bus.mem_i_addr, bus.mem_d_addr, bus.mem_length, bus.mem_wdata});
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_w(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  function automatic logic [16:0] rand_addr();
    return 17'h2000 + (17'($urandom) & 17'h1DFFC);
  endfunction
  task automatic d_write(input logic [16:0] wa, input logic [31:0] q [$], input string tag);
    int len = q.size();
    int n = 0, beats = 0;
    logic [14:0] w;
    bus.d_req = 1; bus.d_op = MEM_WRITE; bus.d_addr = wa; bus.d_len = 4'(len); bus.d_wdata = q[0];
    do begin
      step(); n++;
      if (n == 1) begin bus.d_addr = 17'($urandom); bus.d_len = 4'($urandom_range(1, 8)); bus.d_op = MEM_READ_BURST; end
      bus.d_wdata = q[beats < len ? beats : len - 1];
      if (bus.d_beat) beats++;
    end while (!bus.d_done && n < 20);
    bus.d_req = 0; bus.d_op = MEM_NOP;
    check({tag, "_lat"}, n, len);
    check({tag, "_beats"}, beats, len);
    for (int k = 0; k < len; k++) begin w = wa[16:2] + 15'(k); ref_mem[int'(w)] = q[k]; end
    step();
    check_w({tag, "_cool"}, all_out(), '0);
    for (int k = 0; k < len; k++) begin w = wa[16:2] + 15'(k); check({tag, "_mem"}, mem_word(w), ref_word(w)); end
    step();
  endtask
  task automatic d_burst(input logic [16:0] ba, input string tag);
    int n = 0, beats = 0;
    logic [14:0] w;
    bus.d_req = 1; bus.d_op = MEM_READ_BURST; bus.d_addr = ba; bus.d_len = 4'd1;
    do begin
      step(); n++;
      if (n == 1) begin bus.d_addr = 17'($urandom); bus.d_op = MEM_WRITE; end
      if (bus.d_beat) begin
        w = ba[16:2] + 15'(beats);
        check({tag, "_data"}, bus.d_rdata, ref_word(w));
        beats++;
      end
    end while (!bus.d_done && n < 20);
    bus.d_req = 0; bus.d_op = MEM_NOP;
    check({tag, "_lat"}, n, 9);
    check({tag, "_beats"}, beats, 8);
    step();
    check_w({tag, "_cool"}, all_out(), '0);
    step();
  endtask
  task automatic d_read(input logic [16:0] ra, input string tag);
    int n = 0;
    bus.d_req = 1; bus.d_op = MEM_READ; bus.d_addr = ra; bus.d_len = 4'd1;
    do begin
      step(); n++;
      if (n == 1) begin
        bus.d_addr = 17'($urandom); bus.d_op = MEM_WRITE;
        check({tag, "_iaddr"}, 32'(bus.mem_i_addr), 32'(ra));
        check({tag, "_sig"}, 32'({bus.mem_i_signal, bus.mem_d_signal}), 32'({MEM_NOP, MEM_READ}));
      end
    end while (!bus.d_done && n < 10);
    bus.d_req = 0; bus.d_op = MEM_NOP;
    check({tag, "_lat"}, n, 2);
    check({tag, "_beat"}, 32'(bus.d_beat), 1);
    check({tag, "_data"}, bus.d_rdata, ref_word(ra[16:2]));
    step();
    check_w({tag, "_cool"}, all_out(), '0);
    step();
  endtask
  task automatic i_read(input logic [16:0] ra, input string tag);
    int n = 0;
    bus.i_req = 1; bus.i_addr = ra;
    do begin step(); n++; end while (!bus.i_done && n < 10);
    check({tag, "_lat"}, n, 2);
    check({tag, "_data"}, bus.i_rdata, ref_word(ra[16:2]));
    bus.i_req = 0;
    step();
    check_w({tag, "_cool"}, all_out(), '0);
    step();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_op = MEM_NOP;
    bus.d_addr = '0; bus.d_len = '0; bus.d_wdata = '0;
    rst_n = 0;
    step(); step();
    check_w("reset_outs", all_out(), '0);
    rst_n = 1;
    step();
    dq = {};
    for (int k = 0; k < 8; k++) dq.push_back($urandom);
    bus.d_req = 1; bus.d_op = MEM_WRITE; bus.d_addr = 17'h1000; bus.d_len = 4'd8; bus.d_wdata = dq[0];
    for (int k = 0; k < 3; k++) begin step(); bus.d_wdata = dq[k + 1]; end
    check("rst_pre_sig", 32'(bus.mem_d_signal), 32'(MEM_WRITE));
    rst_n = 0; bus.d_req = 0; bus.d_op = MEM_NOP;
    step();
    check_w("rst_mid_outs", all_out(), '0);
    step();
    check_w("rst_hold_outs", all_out(), '0);
    rst_n = 1;
    step();
    check_w("rst_idle_outs", all_out(), '0);
    dq = {32'hDEADBEEF};
    d_write(17'h100, dq, "wr_len1");
    i_read(17'h100, "i_rd_100");
    dq = {32'd1, 32'd2, 32'd3, 32'd4};
    d_write(17'h40, dq, "wr_40");
    d_burst(17'h200, "burst_200");
    ia = rand_addr(); da = rand_addr();
    bus.d_req = 1; bus.d_op = MEM_READ; bus.d_addr = da; bus.i_req = 1; bus.i_addr = ia;
    cyc = 0; dcyc = -1; icyc = -1;
    do begin
      step(); cyc++;
      if (bus.d_done) begin dcyc = cyc; check("both_d_data", bus.d_rdata, ref_word(da[16:2])); bus.d_req = 0; end
      if (bus.i_done) begin icyc = cyc; check("both_i_data", bus.i_rdata, ref_word(ia[16:2])); end
    end while (icyc < 0 && cyc < 20);
    bus.i_req = 0; bus.d_op = MEM_NOP;
    check("both_d_lat", dcyc, 2);
    check("both_i_lat", icyc, 6);
    step(); step();
    ia = rand_addr(); da = rand_addr();
    bus.d_req = 1; bus.d_op = MEM_READ; bus.d_addr = da; bus.i_req = 1; bus.i_addr = ia;
    for (int g = 0; g < 15; g++) begin
      c = 0;
      do begin step(); c++; end while (!bus.i_done && !bus.d_done && c < 12);
      who = bus.d_done ? 1 : bus.i_done ? 2 : 0;
      exp_who = (g % 5 == 4) ? 2 : 1;
      check("starve_order", who, exp_who);
      check("starve_gap", c, g == 0 ? 2 : 4);
      if (bus.d_done) check("starve_d_data", bus.d_rdata, ref_word(da[16:2]));
      if (bus.i_done) check("starve_i_data", bus.i_rdata, ref_word(ia[16:2]));
    end
    bus.i_req = 0; bus.d_req = 0; bus.d_op = MEM_NOP;
    step(); step();
    for (int r = 0; r < 4; r++) begin
      a = rand_addr();
      dq = {};
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) dq.push_back($urandom);
      if (dq.size() == 0) dq.push_back($urandom);
      d_write(a, dq, "rnd_wr");
      d_burst(a, "rnd_burst");
      d_read(rand_addr(), "rnd_drd");
      i_read(a, "rnd_ird");
    end
    dq = {};
    for (int k = 0; k < 8; k++) dq.push_back($urandom);
    d_write(17'h1FFE0, dq, "wr_len8");
    dq = {$urandom, $urandom, $urandom, $urandom};
    d_write(17'h1FFF8, dq, "wrap_wr");
    d_burst(17'h1FFF0, "wrap_burst");
    d_read(17'h0, "wrap_rd0");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
